// File: rtl/latch_bank_ctrl.sv
// Two-requester round-robin write controller for a latch bank: SETUP, OPEN for OPEN_CYC cycles, then HOLD with ack.
// Optional software clear is enabled by defining LATCH_BANK_CLR_EN, which adds the clr_req input.
module latch_bank_ctrl #(
  parameter int DW       = 8,
  parameter int AW       = 2,
  parameter int OPEN_CYC = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic [AW-1:0]     addr0,
  input  logic [AW-1:0]     addr1,
  input  logic [DW-1:0]     data0,
  input  logic [DW-1:0]     data1,
`ifdef LATCH_BANK_CLR_EN
  input  logic              clr_req,
`endif
  output logic              ack0,
  output logic              ack1,
  output logic [2**AW-1:0]  lat_en,
  output logic [DW-1:0]     lat_d,
  output logic              lat_rst,
  output logic              busy
);

  localparam int OPEN_EFF = (OPEN_CYC < 1) ? 1 : OPEN_CYC;
  localparam int CW       = (OPEN_EFF < 2) ? 1 : $clog2(OPEN_EFF + 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    OPEN,
    HOLD
`ifdef LATCH_BANK_CLR_EN
    , CLEAR
`endif
  } state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [AW-1:0]   addr_q, addr_n;
  logic [DW-1:0]   data_n;
  logic            win_q, win_n;
  logic            last_q, last_n;
  logic            grant1;
  logic [2**AW-1:0] lat_en_n;
  logic            ack0_n, ack1_n, busy_n, lat_rst_n;
`ifdef LATCH_BANK_CLR_EN
  logic            clr_pend, clr_pend_n, clr_any;
`endif

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    addr_n  = addr_q;
    data_n  = lat_d;
    win_n   = win_q;
    last_n  = last_q;
    grant1  = req1 && (!req0 || (last_q == 1'b0));
`ifdef LATCH_BANK_CLR_EN
    clr_any    = clr_pend | clr_req;
    clr_pend_n = clr_any;
`endif
    case (state)
      IDLE: begin
`ifdef LATCH_BANK_CLR_EN
        if (clr_any) begin
          state_n    = CLEAR;
          clr_pend_n = 1'b0;
        end else
`endif
        if (req0 || req1) begin
          win_n   = grant1;
          last_n  = grant1;
          addr_n  = grant1 ? addr1 : addr0;
          data_n  = grant1 ? data1 : data0;
          state_n = SETUP;
        end
      end
      SETUP: begin
        state_n = OPEN;
        cnt_n   = CW'(OPEN_EFF - 1);
      end
      OPEN: begin
        if (cnt == '0) state_n = HOLD;
        else           cnt_n   = cnt - CW'(1);
      end
      HOLD: begin
        state_n = IDLE;
`ifdef LATCH_BANK_CLR_EN
        // A clear requested during the transfer goes out right after the ack.
        if (clr_any) begin
          state_n    = CLEAR;
          clr_pend_n = 1'b0;
        end
`endif
      end
`ifdef LATCH_BANK_CLR_EN
      CLEAR: state_n = IDLE;
`endif
      default: state_n = IDLE;
    endcase

    // Outputs are precomputed from the next state so they come straight off flops.
    lat_en_n = '0;
    if (state_n == OPEN) lat_en_n[addr_n] = 1'b1;
    ack0_n    = (state_n == HOLD) && !win_n;
    ack1_n    = (state_n == HOLD) && win_n;
    busy_n    = (state_n != IDLE);
`ifdef LATCH_BANK_CLR_EN
    lat_rst_n = (state_n == CLEAR);
`else
    lat_rst_n = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      addr_q   <= '0;
      win_q    <= 1'b0;
      last_q   <= 1'b1;
      lat_en   <= '0;
      lat_d    <= '0;
      ack0     <= 1'b0;
      ack1     <= 1'b0;
      busy     <= 1'b0;
      lat_rst  <= 1'b1;
`ifdef LATCH_BANK_CLR_EN
      clr_pend <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      addr_q   <= addr_n;
      win_q    <= win_n;
      last_q   <= last_n;
      lat_en   <= lat_en_n;
      lat_d    <= data_n;
      ack0     <= ack0_n;
      ack1     <= ack1_n;
      busy     <= busy_n;
      lat_rst  <= lat_rst_n;
`ifdef LATCH_BANK_CLR_EN
      clr_pend <= clr_pend_n;
`endif
    end
  end

endmodule

// File: tb/tb_latch_bank_ctrl.sv
// Randomized scoreboard bench for latch_bank_ctrl: expected transfers are queued in round-robin order at issue time.
// A negedge monitor pops one entry per ack and checks requester, address, data, open length and busy length.
module tb_latch_bank_ctrl;
  localparam int DW = 8, AW = 2, OPEN_CYC = 2, NW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req0, req1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] data0, data1;
  logic          ack0, ack1, lat_rst, busy;
  logic [NW-1:0] lat_en;
  logic [DW-1:0] lat_d;

  latch_bank_ctrl #(.DW(DW), .AW(AW), .OPEN_CYC(OPEN_CYC)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1),
    .addr0(addr0), .addr1(addr1),
    .data0(data0), .data1(data1),
    .ack0(ack0), .ack1(ack1),
    .lat_en(lat_en), .lat_d(lat_d), .lat_rst(lat_rst), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {int who; int addr; int data;} txn_t;
  txn_t exp_q[$];
  txn_t cur;
  int checks = 0, failures = 0;
  int model_last = 1;
  bit mon_en = 1'b0;
  logic [NW-1:0] prev_en = '0;
  logic [DW-1:0] prev_d = '0;
  int open_cnt = 0, busy_cnt = 0, seen_addr = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: per-cycle invariants plus one scoreboard pop per ack.
  always @(negedge clk) begin
    if (mon_en) begin
      if (lat_rst) begin
        open_cnt = 0;
        busy_cnt = 0;
        prev_en  = '0;
        prev_d   = lat_d;
      end else begin
        if (lat_en != '0) begin
          checkOutput("lat_en_onehot", 32'($onehot(lat_en)), 32'd1);
          open_cnt++;
          for (int i = 0; i < NW; i++) if (lat_en[i]) seen_addr = i;
        end
        if (lat_en != '0 || prev_en != '0) checkOutput("lat_d_stable", 32'(lat_d), 32'(prev_d));
        if (busy) busy_cnt++;
        if (ack0 || ack1) begin
          checkOutput("ack_exclusive", 32'(ack0 & ack1), 32'd0);
          if (exp_q.size() == 0) begin
            checkOutput("unexpected_ack", 32'd1, 32'd0);
          end else begin
            cur = exp_q.pop_front();
            checkOutput("grant_who", ack1 ? 32'd1 : 32'd0, 32'(cur.who));
            checkOutput("lat_addr", 32'(seen_addr), 32'(cur.addr));
            checkOutput("lat_data", 32'(lat_d), 32'(cur.data));
            checkOutput("open_cycles", 32'(open_cnt), 32'(OPEN_CYC));
            checkOutput("busy_cycles", 32'(busy_cnt), 32'(OPEN_CYC + 2));
          end
          open_cnt = 0;
          busy_cnt = 0;
        end
        prev_en = lat_en;
        prev_d  = lat_d;
      end
    end
  end

  // Issue one batch of requests, queue the expected round-robin order, hold each req until its ack.
  task automatic applyStimulus(input bit r0, input bit r1,
                               input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                               input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    txn_t t0, t1;
    bit a0s, a1s, done;
    t0 = '{who: 0, addr: int'(a0), data: int'(d0)};
    t1 = '{who: 1, addr: int'(a1), data: int'(d1)};
    if (r0 && r1) begin
      if (model_last == 0) begin exp_q.push_back(t1); exp_q.push_back(t0); model_last = 0; end
      else                 begin exp_q.push_back(t0); exp_q.push_back(t1); model_last = 1; end
    end else if (r0) begin
      exp_q.push_back(t0); model_last = 0;
    end else if (r1) begin
      exp_q.push_back(t1); model_last = 1;
    end
    @(posedge clk); #1;
    req0 = r0; addr0 = a0; data0 = d0;
    req1 = r1; addr1 = a1; data1 = d1;
    done = !(r0 || r1);
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      a0s = ack0; a1s = ack1;
      @(posedge clk); #1;
      if (a0s) req0 = 1'b0;
      if (a1s) req1 = 1'b0;
      done = !req0 && !req1;
    end
    if (!done) begin
      checkOutput("step_timeout", 32'd1, 32'd0);
      req0 = 1'b0; req1 = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0;
    addr0 = '0; addr1 = '0; data0 = '0; data1 = '0;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); @(negedge clk);
      checkOutput("rst_lat_rst", 32'(lat_rst), 32'd1);
      checkOutput("rst_lat_en", 32'(lat_en), 32'd0);
      checkOutput("rst_lat_d", 32'(lat_d), 32'd0);
      checkOutput("rst_acks", 32'({ack0, ack1}), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("release_lat_rst", 32'(lat_rst), 32'd0);
    model_last = 1;
    mon_en = 1'b1;

    applyStimulus(1, 0, 2'd2, 8'hA5, 2'd0, 8'h00);
    applyStimulus(1, 1, 2'd1, 8'h11, 2'd3, 8'h33);
    applyStimulus(1, 1, 2'd0, 8'h5A, 2'd2, 8'hC3);

    for (int n = 0; n < 24; n++) begin
      int mode;
      mode = $urandom_range(1, 3);
      applyStimulus(mode[0], mode[1], AW'($urandom), DW'($urandom), AW'($urandom), DW'($urandom));
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end

    // Reset during OPEN aborts the transfer with no ack; pointer returns to favouring requester 0.
    @(posedge clk); #1;
    req0 = 1'b1; addr0 = 2'd3; data0 = 8'h77;
    begin
      bit seen;
      seen = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
        @(negedge clk);
        seen = (lat_en != '0);
      end
      checkOutput("reach_open", 32'(seen), 32'd1);
    end
    rst_n = 1'b0; req0 = 1'b0;
    @(negedge clk);
    checkOutput("abort_lat_en", 32'(lat_en), 32'd0);
    checkOutput("abort_lat_rst", 32'(lat_rst), 32'd1);
    checkOutput("abort_no_ack", 32'({ack0, ack1}), 32'd0);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("abort_release_lat_rst", 32'(lat_rst), 32'd0);
    checkOutput("abort_release_no_ack", 32'({ack0, ack1}), 32'd0);
    model_last = 1;
    applyStimulus(1, 0, 2'd3, 8'h77, 2'd0, 8'h00);
    applyStimulus(1, 1, 2'd0, 8'h9C, 2'd1, 8'hE4);

    repeat (5) @(negedge clk);
    checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
